// File: rtl/f1_pkg.sv
// Shared types and defaults for the F1 start-light reaction timer.
// The thermometer helper gives the legal light-bar pattern for a given level.
package f1_pkg;

  localparam int DEF_CNT_W    = 12;
  localparam int DEF_N_LIGHTS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMING  = 3'd1,
    ALL_ON  = 3'd2,
    TIMING  = 3'd3,
    DONE    = 3'd4,
    JUMP    = 3'd5,
    SEQ_ERR = 3'd6
  } state_t;

  function automatic logic [31:0] therm_pattern(input logic [31:0] lvl);
    if (lvl >= 32'd32) return '1;
    return (32'd1 << lvl) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw button plus a rising-edge detector.
// rise is high for one cycle, two cycles after d is first captured.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta, sync, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/f1_reaction_timer.sv
// Driver reaction timer: follows the start-light sequence, times lights-out
// to button press in ticks, and flags jump starts and illegal patterns.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int N_LIGHTS = DEF_N_LIGHTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LIGHTS-1:0] lights,
  input  logic                tick,
  input  logic                btn,
  output logic [CNT_W-1:0]    react_ms,
  output logic                valid,
  output logic                jump_start,
  output logic                seq_err,
  output logic                busy
);

  localparam int LVL_W = $clog2(N_LIGHTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic [LVL_W-1:0]  lvl, lvl_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              press;
  logic              go_arm, go_jump, go_done, go_seq;
  logic [N_LIGHTS-1:0] pat_one, pat_cur, pat_nxt, pat_full;

  btn_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .d    (btn),
    .rise (press)
  );

  assign pat_one  = N_LIGHTS'(therm_pattern(32'd1));
  assign pat_cur  = N_LIGHTS'(therm_pattern(32'(lvl)));
  assign pat_nxt  = N_LIGHTS'(therm_pattern(32'(lvl) + 32'd1));
  assign pat_full = N_LIGHTS'(therm_pattern(32'(N_LIGHTS)));

  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    cnt_nx   = cnt;
    go_arm   = 1'b0;
    go_jump  = 1'b0;
    go_done  = 1'b0;
    go_seq   = 1'b0;
    case (state)
      IDLE: begin
        if (lights == pat_one) begin
          state_nx = ARMING;
          lvl_nx   = LVL_W'(1);
          go_arm   = 1'b1;
        end
      end
      ARMING: begin
        // A press outranks an illegal pattern seen in the same cycle.
        if (press) begin
          state_nx = JUMP;
          go_jump  = 1'b1;
        end else if (lights == pat_cur) begin
          state_nx = ARMING;
        end else if (lights == pat_nxt) begin
          lvl_nx = lvl + LVL_W'(1);
          if (lvl_nx == LVL_W'(N_LIGHTS)) state_nx = ALL_ON;
        end else begin
          state_nx = SEQ_ERR;
          go_seq   = 1'b1;
        end
      end
      ALL_ON: begin
        if (press) begin
          state_nx = JUMP;
          go_jump  = 1'b1;
        end else if (lights == pat_full) begin
          state_nx = ALL_ON;
        end else if (lights == '0) begin
          state_nx = TIMING;
          cnt_nx   = '0;
        end else begin
          state_nx = SEQ_ERR;
          go_seq   = 1'b1;
        end
      end
      TIMING: begin
        if (press) begin
          state_nx = DONE;
          go_done  = 1'b1;
        end else if (lights != '0) begin
          state_nx = SEQ_ERR;
          go_seq   = 1'b1;
        end else if (tick && (cnt != CNT_MAX)) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE, JUMP, SEQ_ERR: begin
        if (lights == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lvl        <= '0;
      cnt        <= '0;
      react_ms   <= '0;
      valid      <= 1'b0;
      jump_start <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state <= state_nx;
      lvl   <= lvl_nx;
      cnt   <= cnt_nx;
      valid <= go_done;
      if (go_done) react_ms <= cnt;
      else if (go_jump) react_ms <= '0;
      if (go_arm) jump_start <= 1'b0;
      else if (go_jump) jump_start <= 1'b1;
      if (go_arm) seq_err <= 1'b0;
      else if (go_seq) seq_err <= 1'b1;
    end
  end

  assign busy = (state == ARMING) || (state == ALL_ON) || (state == TIMING);

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: expected reaction times are queued
// when a press is issued and checked by a monitor on each valid pulse.
module tb_f1_reaction_timer;

  localparam int CNT_W    = 12;
  localparam int N_LIGHTS = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N_LIGHTS-1:0] lights = '0;
  logic                tick = 1'b0;
  logic                btn = 1'b0;
  logic [CNT_W-1:0]    react_ms;
  logic                valid, jump_start, seq_err, busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  f1_reaction_timer #(.CNT_W(CNT_W), .N_LIGHTS(N_LIGHTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .lights     (lights),
    .tick       (tick),
    .btn        (btn),
    .react_ms   (react_ms),
    .valid      (valid),
    .jump_start (jump_start),
    .seq_err    (seq_err),
    .busy       (busy)
  );

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    int e;
    if (valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got react_ms=%0d, required no pulse", react_ms);
      end else begin
        e = exp_q.pop_front();
        if (react_ms !== CNT_W'(e)) begin
          errors++;
          $display("FAIL react_ms: got %0d, required %0d", react_ms, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic arm_all();
    for (int i = 1; i <= N_LIGHTS; i++) begin
      lights = N_LIGHTS'((1 << i) - 1);
      cyc();
    end
    lights = '0;
    cyc();
    chk("busy_timing", 32'(busy), 32'd1);
  endtask

  task automatic give_ticks(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  // Press arrives 3 edges after btn rises; with coincide a tick lands on that edge.
  task automatic press_and_check(input int exp, input bit coincide);
    exp_q.push_back(exp);
    btn = 1'b1;
    cyc();
    cyc();
    tick = coincide;
    cyc();
    tick = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL valid_missing: pending %0d, required 0", exp_q.size());
      exp_q.delete();
    end
    chk("busy_after", 32'(busy), 32'd0);
    chk("react_hold", 32'(react_ms), 32'(exp));
    btn = 1'b0;
    cyc();
  endtask

  task automatic full_run(input int n, input bit gaps, input bit coincide);
    arm_all();
    give_ticks(n, gaps);
    press_and_check((n > CMAX) ? CMAX : n, coincide);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) cyc();
    chk("rst_react", 32'(react_ms), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_jump", 32'(jump_start), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cyc();

    // Idle ignores non-start patterns and presses
    lights = 8'h03;
    cyc();
    chk("idle_ignore", 32'(busy), 32'd0);
    btn = 1'b1;
    repeat (4) cyc();
    btn = 1'b0;
    cyc();
    chk("idle_press", 32'(jump_start), 32'd0);
    lights = '0;
    cyc();

    full_run(250, 1'b0, 1'b0);

    arm_all();
    chk("react_hold_next", 32'(react_ms), 32'd250);
    give_ticks(17, 1'b1);
    press_and_check(17, 1'b1);

    // Jump start at five lights
    for (int i = 1; i <= 5; i++) begin
      lights = N_LIGHTS'((1 << i) - 1);
      cyc();
    end
    btn = 1'b1;
    repeat (3) cyc();
    chk("jump_set", 32'(jump_start), 32'd1);
    chk("jump_react", 32'(react_ms), 32'd0);
    chk("jump_busy", 32'(busy), 32'd0);
    btn = 1'b0;
    lights = '0;
    cyc();
    chk("jump_sticky", 32'(jump_start), 32'd1);
    lights = 8'h01;
    cyc();
    chk("jump_clear", 32'(jump_start), 32'd0);
    chk("arm_busy", 32'(busy), 32'd1);

    // Illegal step 0x03 -> 0x0F
    lights = 8'h03;
    cyc();
    lights = 8'h0F;
    cyc();
    chk("seq_set", 32'(seq_err), 32'd1);
    chk("seq_busy", 32'(busy), 32'd0);
    lights = '0;
    cyc();
    chk("seq_sticky", 32'(seq_err), 32'd1);
    lights = 8'h01;
    cyc();
    chk("seq_clear", 32'(seq_err), 32'd0);

    // Press and illegal pattern on the same edge: press wins
    lights = 8'h03;
    cyc();
    btn = 1'b1;
    cyc();
    cyc();
    lights = 8'h0A;
    cyc();
    chk("prio_jump", 32'(jump_start), 32'd1);
    chk("prio_seq", 32'(seq_err), 32'd0);
    btn = 1'b0;
    lights = '0;
    cyc();

    // Lights back on during timing
    arm_all();
    give_ticks(5, 1'b0);
    lights = 8'h01;
    cyc();
    chk("timing_seq", 32'(seq_err), 32'd1);
    chk("timing_seq_busy", 32'(busy), 32'd0);
    lights = '0;
    cyc();

    repeat (5) full_run($urandom_range(0, 400), 1'b1, 1'(($urandom_range(0, 1))));

    full_run(5000, 1'b0, 1'b0);

    // Reset in the middle of a measurement
    arm_all();
    give_ticks(40, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_react", 32'(react_ms), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_jump", 32'(jump_start), 32'd0);
    chk("mid_rst_seq", 32'(seq_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    full_run(123, 1'b1, 1'b0);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
